fwd_operand_stage: RTL and testbench

//  Pipelined successor to the single-cycle operand/destination selectors. Picks each source operand (rs, rt)

---
 rtl/fwd_operand_stage_if.sv | 44 ++++
 rtl/fwd_operand_stage.sv | 118 +++++++++++
 tb/tb_fwd_operand_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_operand_stage_if.sv
// Decode-to-execute bundle for the operand stage: upstream request,
// forwarding sources, downstream registered operands and stall status.
interface fwd_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int CNTW  = 16
);
    logic                  up_valid;
    logic                  up_ready;
    logic [4:0]            rs_addr;
    logic [4:0]            rt_addr;
    logic [4:0]            rd_addr;
    logic [1:0]            dst_sel;
    logic [WIDTH-1:0]      rf_rs_data;
    logic [WIDTH-1:0]      rf_rt_data;
    logic [NSRC-1:0]       fwd_we;
    logic [NSRC*5-1:0]     fwd_addr;
    logic [NSRC*WIDTH-1:0] fwd_data;
    logic [NSRC-1:0]       fwd_rdy;
    logic                  flush;
    logic                  dn_valid;
    logic                  dn_ready;
    logic [WIDTH-1:0]      rs_val;
    logic [WIDTH-1:0]      rt_val;
    logic [4:0]            dst_addr;
    logic                  hazard;
    logic [CNTW-1:0]       stall_cnt;

    modport slave (
        input  up_valid, rs_addr, rt_addr, rd_addr, dst_sel,
        input  rf_rs_data, rf_rt_data,
        input  fwd_we, fwd_addr, fwd_data, fwd_rdy,
        input  flush, dn_ready,
        output up_ready, dn_valid, rs_val, rt_val, dst_addr, hazard, stall_cnt
    );

    modport master (
        output up_valid, rs_addr, rt_addr, rd_addr, dst_sel,
        output rf_rs_data, rf_rt_data,
        output fwd_we, fwd_addr, fwd_data, fwd_rdy,
        output flush, dn_ready,
        input  up_ready, dn_valid, rs_val, rt_val, dst_addr, hazard, stall_cnt
    );
endinterface

// File: rtl/fwd_operand_stage.sv
// Decode/execute operand stage: forwarding-aware operand and destination
// select, operand-not-ready hazard detection, and a 1-entry valid/ready register.
module fwd_operand_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fwd_operand_stage_if.slave   bus
);

    logic [WIDTH-1:0] rs_sel;
    logic [WIDTH-1:0] rt_sel;
    logic             rs_haz;
    logic             rt_haz;
    logic [4:0]       dst_sel_addr;
    logic             hazard;
    logic             up_ready;
    logic             transfer;

    logic             dn_valid_q;
    logic [WIDTH-1:0] rs_val_q;
    logic [WIDTH-1:0] rt_val_q;
    logic [4:0]       dst_addr_q;
    logic [CNTW-1:0]  stall_cnt_q;

    // Returns {hazard, value}. The nearest matching source wins outright; if it
    // is not ready we stall rather than fall back to an older producer.
    function automatic logic [WIDTH:0] pick_operand(
        input logic [4:0]            addr,
        input logic [WIDTH-1:0]      rf_data,
        input logic [NSRC-1:0]       we,
        input logic [NSRC*5-1:0]     faddr,
        input logic [NSRC*WIDTH-1:0] fdata,
        input logic [NSRC-1:0]       frdy
    );
        logic             found;
        logic [WIDTH:0]   res;
        found = 1'b0;
        res   = {1'b0, rf_data};
        if (addr == 5'd0) begin
            res = '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (!found && we[i] && (faddr[5*i +: 5] == addr)) begin
                    found = 1'b1;
                    if (frdy[i]) begin
                        res = {1'b0, fdata[WIDTH*i +: WIDTH]};
                    end else begin
                        res = {1'b1, {WIDTH{1'b0}}};
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {rs_haz, rs_sel} = pick_operand(bus.rs_addr, bus.rf_rs_data, bus.fwd_we,
                                        bus.fwd_addr, bus.fwd_data, bus.fwd_rdy);
        {rt_haz, rt_sel} = pick_operand(bus.rt_addr, bus.rf_rt_data, bus.fwd_we,
                                        bus.fwd_addr, bus.fwd_data, bus.fwd_rdy);
    end

    always_comb begin
        dst_sel_addr = 5'd0;
        case (bus.dst_sel)
            2'b00:   dst_sel_addr = bus.rt_addr;
            2'b01:   dst_sel_addr = bus.rd_addr;
            2'b10:   dst_sel_addr = 5'd31;
            default: dst_sel_addr = 5'd0;
        endcase
    end

    // Flush deliberately does not gate up_ready: a flushed transfer is consumed.
    assign hazard   = bus.up_valid && (rs_haz || rt_haz);
    assign up_ready = !hazard && (!dn_valid_q || bus.dn_ready);
    assign transfer = bus.up_valid && up_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dn_valid_q <= 1'b0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            dst_addr_q <= 5'd0;
        end else if (bus.flush) begin
            dn_valid_q <= 1'b0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            dst_addr_q <= 5'd0;
        end else if (transfer) begin
            dn_valid_q <= 1'b1;
            rs_val_q   <= rs_sel;
            rt_val_q   <= rt_sel;
            dst_addr_q <= dst_sel_addr;
        end else if (dn_valid_q && bus.dn_ready) begin
            dn_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (hazard && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

    assign bus.up_ready  = up_ready;
    assign bus.hazard    = hazard;
    assign bus.dn_valid  = dn_valid_q;
    assign bus.rs_val    = rs_val_q;
    assign bus.rt_val    = rt_val_q;
    assign bus.dst_addr  = dst_addr_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed bench for fwd_operand_stage; small counter width so saturation is reachable.
module tb_fwd_operand_stage;
    localparam int WIDTH = 32;
    localparam int NSRC  = 3;
    localparam int CNTW  = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_stall;

    fwd_operand_stage_if #(.WIDTH(WIDTH), .NSRC(NSRC), .CNTW(CNTW)) bus ();

    fwd_operand_stage #(.WIDTH(WIDTH), .NSRC(NSRC), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.up_valid   = 1'b0;
        bus.rs_addr    = 5'd0;
        bus.rt_addr    = 5'd0;
        bus.rd_addr    = 5'd0;
        bus.dst_sel    = 2'b11;
        bus.rf_rs_data = '0;
        bus.rf_rt_data = '0;
        bus.fwd_we     = '0;
        bus.fwd_addr   = '0;
        bus.fwd_data   = '0;
        bus.fwd_rdy    = '0;
        bus.flush      = 1'b0;
        bus.dn_ready   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        checks++; if (bus.dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid got %0b want 0", bus.dn_valid); end
        checks++; if (bus.rs_val !== 32'h0) begin errors++; $display("FAIL reset_rs_val got %h want 0", bus.rs_val); end
        checks++; if (bus.dst_addr !== 5'd0) begin errors++; $display("FAIL reset_dst got %0d want 0", bus.dst_addr); end
        checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
        @(negedge clk);
        reset = 1'b1;
        exp_stall = 0;
        tick();
    endtask

    task automatic test_no_match();
        bus.up_valid = 1'b1; bus.rs_addr = 5'd3; bus.rf_rs_data = 32'h11;
        bus.rt_addr = 5'd4; bus.rf_rt_data = 32'h22; bus.rd_addr = 5'd5; bus.dst_sel = 2'b01;
        #1;
        checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL nomatch_up_ready got %0b want 1", bus.up_ready); end
        tick();
        bus.up_valid = 1'b0; bus.dn_ready = 1'b1;
        checks++; if (bus.dn_valid !== 1'b1) begin errors++; $display("FAIL nomatch_dn_valid got %0b want 1", bus.dn_valid); end
        checks++; if (bus.rs_val !== 32'h11) begin errors++; $display("FAIL nomatch_rs got %h want 11", bus.rs_val); end
        checks++; if (bus.rt_val !== 32'h22) begin errors++; $display("FAIL nomatch_rt got %h want 22", bus.rt_val); end
        checks++; if (bus.dst_addr !== 5'd5) begin errors++; $display("FAIL nomatch_dst got %0d want 5", bus.dst_addr); end
        tick();
        checks++; if (bus.dn_valid !== 1'b0) begin errors++; $display("FAIL consume_dn_valid got %0b want 0", bus.dn_valid); end
        checks++; if (bus.rs_val !== 32'h11) begin errors++; $display("FAIL consume_hold_rs got %h want 11", bus.rs_val); end
    endtask

    task automatic test_dst();
        logic [4:0] want [4];
        want[0] = 5'd7; want[1] = 5'd9; want[2] = 5'd31; want[3] = 5'd0;
        bus.rs_addr = 5'd1; bus.rt_addr = 5'd7; bus.rd_addr = 5'd9; bus.dn_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.up_valid = 1'b1; bus.dst_sel = 2'(s);
            tick();
            checks++; if (bus.dst_addr !== want[s]) begin errors++; $display("FAIL dst_sel%0d got %0d want %0d", s, bus.dst_addr, want[s]); end
        end
        bus.up_valid = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        bus.dn_ready = 1'b1; bus.up_valid = 1'b1;
        bus.rs_addr = 5'd3; bus.rf_rs_data = 32'h11; bus.rt_addr = 5'd4; bus.rf_rt_data = 32'h22;
        bus.fwd_we = 3'b011; bus.fwd_rdy = 3'b011;
        bus.fwd_addr = {5'd0, 5'd3, 5'd3};
        bus.fwd_data = {32'h0, 32'hBB, 32'hAA};
        tick();
        checks++; if (bus.rs_val !== 32'hAA) begin errors++; $display("FAIL prio_src0 got %h want AA", bus.rs_val); end
        checks++; if (bus.rt_val !== 32'h22) begin errors++; $display("FAIL prio_rt_rf got %h want 22", bus.rt_val); end
        bus.fwd_we = 3'b010;
        tick();
        checks++; if (bus.rs_val !== 32'hBB) begin errors++; $display("FAIL prio_src1 got %h want BB", bus.rs_val); end
        checks++; if (bus.dn_valid !== 1'b1) begin errors++; $display("FAIL prio_b2b_valid got %0b want 1", bus.dn_valid); end
        bus.fwd_we = 3'b100; bus.fwd_addr = {5'd4, 5'd0, 5'd0}; bus.fwd_rdy = 3'b100;
        bus.fwd_data = {32'hC4, 32'h0, 32'h0};
        tick();
        checks++; if (bus.rt_val !== 32'hC4) begin errors++; $display("FAIL prio_src2_rt got %h want C4", bus.rt_val); end
    endtask

    task automatic test_hazard();
        bus.up_valid = 1'b1; bus.dn_ready = 1'b1;
        bus.rs_addr = 5'd3; bus.rt_addr = 5'd4; bus.rf_rs_data = 32'h11;
        bus.fwd_we = 3'b011; bus.fwd_rdy = 3'b010;
        bus.fwd_addr = {5'd0, 5'd3, 5'd3};
        bus.fwd_data = {32'h0, 32'hBB, 32'hCC};
        #1;
        checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL haz_flag got %0b want 1", bus.hazard); end
        checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL haz_up_ready got %0b want 0", bus.up_ready); end
        tick(); exp_stall++;
        checks++; if (bus.dn_valid !== 1'b0) begin errors++; $display("FAIL haz_bubble got %0b want 0", bus.dn_valid); end
        tick(); exp_stall++;
        checks++; if (bus.stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL haz_stall got %0d want %0d", bus.stall_cnt, exp_stall); end
        bus.fwd_rdy = 3'b011;
        #1;
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL haz_clear got %0b want 0", bus.hazard); end
        tick();
        checks++; if (bus.rs_val !== 32'hCC) begin errors++; $display("FAIL haz_fwd got %h want CC", bus.rs_val); end
        checks++; if (bus.stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL haz_stall_hold got %0d want %0d", bus.stall_cnt, exp_stall); end
        // rt side hazard alone must also stall
        bus.rs_addr = 5'd1; bus.rt_addr = 5'd3; bus.fwd_rdy = 3'b010;
        #1;
        checks++; if (bus.hazard !== 1'b1) begin errors++; $display("FAIL haz_rt got %0b want 1", bus.hazard); end
        bus.up_valid = 1'b0;
        #1;
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL haz_novalid got %0b want 0", bus.hazard); end
        tick();
    endtask

    task automatic test_zero();
        bus.up_valid = 1'b1; bus.dn_ready = 1'b1;
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0; bus.rf_rs_data = 32'h99; bus.rf_rt_data = 32'h98;
        bus.fwd_we = 3'b001; bus.fwd_addr = '0; bus.fwd_rdy = 3'b000;
        bus.fwd_data = {32'h0, 32'h0, 32'h55};
        #1;
        checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL zero_haz got %0b want 0", bus.hazard); end
        bus.fwd_rdy = 3'b001;
        tick();
        checks++; if (bus.rs_val !== 32'h0) begin errors++; $display("FAIL zero_rs got %h want 0", bus.rs_val); end
        checks++; if (bus.rt_val !== 32'h0) begin errors++; $display("FAIL zero_rt got %h want 0", bus.rt_val); end
        bus.fwd_we = '0;
    endtask

    task automatic test_back_to_back();
        bus.up_valid = 1'b1; bus.dn_ready = 1'b0; bus.fwd_we = '0;
        bus.rs_addr = 5'd3; bus.rf_rs_data = 32'h33; bus.rt_addr = 5'd4; bus.rf_rt_data = 32'h34;
        tick();
        // drains anything left valid from the previous test first
        bus.dn_ready = 1'b1;
        tick();
        bus.dn_ready = 1'b0;
        tick();
        bus.rf_rs_data = 32'h44;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL bp_up_ready c%0d got %0b want 0", c, bus.up_ready); end
            checks++; if (bus.rs_val !== 32'h33 || bus.dn_valid !== 1'b1) begin errors++; $display("FAIL bp_stable c%0d got %h/%0b want 33/1", c, bus.rs_val, bus.dn_valid); end
            tick();
        end
        bus.dn_ready = 1'b1;
        #1;
        checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b want 1", bus.up_ready); end
        tick();
        checks++; if (bus.rs_val !== 32'h44 || bus.dn_valid !== 1'b1) begin errors++; $display("FAIL b2b_load got %h/%0b want 44/1", bus.rs_val, bus.dn_valid); end
    endtask

    task automatic test_flush_and_async_reset();
        bus.up_valid = 1'b1; bus.dn_ready = 1'b1; bus.flush = 1'b1;
        bus.rs_addr = 5'd3; bus.rf_rs_data = 32'h77; bus.dst_sel = 2'b10;
        #1;
        checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL flush_up_ready got %0b want 1", bus.up_ready); end
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.dn_valid !== 1'b0 || bus.rs_val !== 32'h0 || bus.dst_addr !== 5'd0) begin errors++; $display("FAIL flush_clear got %0b/%h/%0d want 0/0/0", bus.dn_valid, bus.rs_val, bus.dst_addr); end
        tick();
        checks++; if (bus.rs_val !== 32'h77 || bus.dst_addr !== 5'd31) begin errors++; $display("FAIL post_flush got %h/%0d want 77/31", bus.rs_val, bus.dst_addr); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.dn_valid !== 1'b0 || bus.rs_val !== 32'h0 || bus.dst_addr !== 5'd0 || bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL async_reset got %0b/%h/%0d/%0d want 0/0/0/0", bus.dn_valid, bus.rs_val, bus.dst_addr, bus.stall_cnt); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (bus.dn_valid !== 1'b1) begin errors++; $display("FAIL after_reset_transfer got %0b want 1", bus.dn_valid); end
    endtask

    task automatic test_saturate();
        bus.up_valid = 1'b1; bus.dn_ready = 1'b1;
        bus.rs_addr = 5'd6; bus.rt_addr = 5'd0;
        bus.fwd_we = 3'b001; bus.fwd_addr = {5'd0, 5'd0, 5'd6}; bus.fwd_rdy = 3'b000;
        bus.flush = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(); exp_stall++;
        end
        checks++; if (bus.stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL stall_flush got %0d want %0d", bus.stall_cnt, exp_stall); end
        bus.flush = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (exp_stall < 15) exp_stall++;
        end
        checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d want 15", bus.stall_cnt); end
        idle_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_stall = 0;
        test_reset();
        test_no_match();
        test_dst();
        test_priority();
        test_hazard();
        test_zero();
        test_back_to_back();
        test_saturate();
        test_flush_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached got running want finished");
        $fatal(1, "timeout");
    end
endmodule
